rcounter_multi_commander: RTL

//  N-channel countdown-timer controller. Each channel holds a BCD min:sec:cs value that can be set,

---
 rtl/rcounter_pkg.sv | 53 +++++
 rtl/rcounter_channel.sv | 112 +++++++++++
 rtl/rcounter_multi_commander.sv | 117 +++++++++++
 3 files changed

// File: rtl/rcounter_pkg.sv
// Shared types and BCD helpers for the multi-channel countdown controller.
package rcounter_pkg;

    typedef enum logic [1:0] {
        StSetup,
        StRun,
        StDone
    } state_e;

    localparam logic [1:0] FLD_CS  = 2'd0;
    localparam logic [1:0] FLD_SEC = 2'd1;
    localparam logic [1:0] FLD_MIN = 2'd2;
    localparam logic [1:0] FLD_RUN = 2'd3;

    typedef struct packed {
        logic [23:0] val;
        logic        is_zero;
    } tick_dec_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] limit);
        if (val == limit) begin
            return 8'h00;
        end else if (val[3:0] == 4'd9) begin
            return {val[7:4] + 4'd1, 4'd0};
        end
        return val + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] val, input logic [7:0] limit);
        if (val == 8'h00) begin
            return limit;
        end else if (val[3:0] == 4'd0) begin
            return {val[7:4] - 4'd1, 4'd9};
        end
        return val - 8'd1;
    endfunction

    // One-centisecond decrement with borrow chain cs -> sec -> min.
    function automatic tick_dec_t bcd_tick_dec(input logic [7:0] mn, input logic [7:0] sc,
                                               input logic [7:0] cs);
        tick_dec_t r;
        logic      b_cs;
        logic      b_sec;
        b_cs          = (cs == 8'h00);
        b_sec         = b_cs && (sc == 8'h00);
        r.val[7:0]    = bcd_dec(cs, 8'h99);
        r.val[15:8]   = b_cs ? bcd_dec(sc, 8'h59) : sc;
        r.val[23:16]  = b_sec ? bcd_dec(mn, 8'h99) : mn;
        r.is_zero     = b_sec && (mn == 8'h00);
        return r;
    endfunction

endpackage

// File: rtl/rcounter_channel.sv
// One countdown channel: SETUP/RUN/DONE FSM, current and reload values, sticky expiry flag.
module rcounter_channel
    import rcounter_pkg::*;
#(
    parameter logic [7:0]  MIN_MAX     = 8'h99,
    parameter logic [23:0] PRESET      = 24'h050000,
    parameter int unsigned AUTO_RELOAD = 0
) (
    input  logic        clk_core,
    input  logic        rst,
    input  logic        tick,
    input  logic        cmd_center,
    input  logic        cmd_right,
    input  logic        cmd_up,
    input  logic        cmd_down,
    input  logic [1:0]  field,
    output logic [23:0] cur,
    output logic        running,
    output logic        in_setup,
    output logic        time_out,
    output logic        expire
);

    state_e      state_q, state_d;
    logic [23:0] cur_q, cur_d;
    logic [23:0] rel_q, rel_d;
    logic        to_q, to_d;
    tick_dec_t   tdec;

    assign tdec = bcd_tick_dec(cur_q[23:16], cur_q[15:8], cur_q[7:0]);

    function automatic logic [23:0] field_step(input logic [23:0] v, input logic [1:0] fld,
                                               input logic inc);
        logic [23:0] r;
        r = v;
        unique case (fld)
            FLD_CS:  r[7:0]   = inc ? bcd_inc(v[7:0], 8'h99)     : bcd_dec(v[7:0], 8'h99);
            FLD_SEC: r[15:8]  = inc ? bcd_inc(v[15:8], 8'h59)    : bcd_dec(v[15:8], 8'h59);
            FLD_MIN: r[23:16] = inc ? bcd_inc(v[23:16], MIN_MAX) : bcd_dec(v[23:16], MIN_MAX);
            default: r = v;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_core) begin
        if (rst) begin
            state_q <= StSetup;
            cur_q   <= PRESET;
            rel_q   <= PRESET;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rel_q   <= rel_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rel_d   = rel_q;
        to_d    = to_q;
        unique case (state_q)
            StSetup: begin
                if (cmd_center) begin
                    state_d = StRun;
                end else if (cmd_up || cmd_down) begin
                    cur_d = field_step(cur_q, field, cmd_up);
                    rel_d = field_step(rel_q, field, cmd_up);
                end
            end
            StRun: begin
                // Center beats the tick, so a pause on the zero tick suppresses expiry.
                if (cmd_center) begin
                    state_d = StSetup;
                end else if (cmd_right) begin
                    cur_d = rel_q;
                end else if (tick) begin
                    if (tdec.is_zero) begin
                        to_d = 1'b1;
                        if (AUTO_RELOAD != 0) begin
                            cur_d = rel_q;
                        end else begin
                            state_d = StDone;
                        end
                    end else begin
                        cur_d = tdec.val;
                    end
                end
            end
            StDone: begin
                cur_d = '0;
                if (cmd_center) begin
                    cur_d   = rel_q;
                    to_d    = 1'b0;
                    state_d = StSetup;
                end
            end
            default: state_d = StSetup;
        endcase
    end

    always_comb begin
        running  = (state_q == StRun);
        in_setup = (state_q == StSetup);
        expire   = (state_q == StRun) && tick && tdec.is_zero && !cmd_center && !cmd_right;
        cur      = cur_q;
        time_out = to_q;
    end

endmodule

// File: rtl/rcounter_multi_commander.sv
// N-channel countdown controller: shared 10 ms prescaler, panel decode, display select and mux.
module rcounter_multi_commander
    import rcounter_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned TICK_DIV    = 1000000,
    parameter logic [7:0]  MIN_MAX     = 8'h99,
    parameter logic [23:0] PRESET      = 24'h050000,
    parameter int unsigned AUTO_RELOAD = 0,
    localparam int unsigned ChW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk_core,
    input  logic            rst,
    input  logic            left_button,
    input  logic            right_button,
    input  logic            up_button,
    input  logic            down_button,
    input  logic            center_button,
    input  logic            ch_next,
    output logic [ChW-1:0]  disp_ch,
    output logic [7:0]      min_o,
    output logic [7:0]      sec_o,
    output logic [7:0]      ms_10_o,
    output logic [1:0]      target,
    output logic [N_CH-1:0] running,
    output logic [N_CH-1:0] time_out,
    output logic            expire_pulse
);

    localparam int unsigned PsW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PsW-1:0]  ps_q, ps_d;
    logic            tick;
    logic [ChW-1:0]  disp_q, disp_d, next_ch;
    logic [1:0]      tgt_q, tgt_d;
    logic            exp_q;
    logic [23:0]     cur_v [N_CH];
    logic [N_CH-1:0] setup_v;
    logic [N_CH-1:0] exp_v;
    logic            one_lrud;
    logic            disp_setup;

    assign tick       = (ps_q == PsW'(TICK_DIV - 1));
    assign ps_d       = tick ? '0 : ps_q + 1'b1;
    // Simultaneous direction buttons cancel each other out entirely.
    assign one_lrud   = $onehot({left_button, right_button, up_button, down_button});
    assign next_ch    = (disp_q == ChW'(N_CH - 1)) ? '0 : disp_q + 1'b1;
    assign disp_setup = setup_v[disp_q];

    always_comb begin
        tgt_d  = tgt_q;
        disp_d = disp_q;
        if (disp_setup && one_lrud && !center_button) begin
            if (left_button && (tgt_q != FLD_MIN)) begin
                tgt_d = tgt_q + 2'd1;
            end
            if (right_button && (tgt_q != FLD_CS)) begin
                tgt_d = tgt_q - 2'd1;
            end
        end
        if (ch_next) begin
            disp_d = next_ch;
            if (setup_v[next_ch]) begin
                tgt_d = FLD_SEC;
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (rst) begin
            ps_q   <= '0;
            disp_q <= '0;
            tgt_q  <= FLD_SEC;
            exp_q  <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            disp_q <= disp_d;
            tgt_q  <= tgt_d;
            exp_q  <= |exp_v;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic sel;
        logic dir_ok;
        assign sel    = (disp_q == ChW'(i));
        assign dir_ok = sel && one_lrud && !center_button;

        rcounter_channel #(
            .MIN_MAX     (MIN_MAX),
            .PRESET      (PRESET),
            .AUTO_RELOAD (AUTO_RELOAD)
        ) u_ch (
            .clk_core   (clk_core),
            .rst        (rst),
            .tick       (tick),
            .cmd_center (center_button && sel),
            .cmd_right  (right_button && dir_ok),
            .cmd_up     (up_button && dir_ok),
            .cmd_down   (down_button && dir_ok),
            .field      (tgt_q),
            .cur        (cur_v[i]),
            .running    (running[i]),
            .in_setup   (setup_v[i]),
            .time_out   (time_out[i]),
            .expire     (exp_v[i])
        );
    end

    assign disp_ch      = disp_q;
    assign min_o        = cur_v[disp_q][23:16];
    assign sec_o        = cur_v[disp_q][15:8];
    assign ms_10_o      = cur_v[disp_q][7:0];
    assign target       = disp_setup ? tgt_q : FLD_RUN;
    assign expire_pulse = exp_q;

endmodule
